program_loader: RTL and testbench
=================================

# program_loader

Upstream front-end of the MIPS core. It receives a byte stream from the UART receiver and assembles big-endian 32-bit words, which it writes into the core's instruction memory. After loading it releases the core in either continuous or single-step mode and reports completion when the core raises `halt_flag`. It drives the core's `reset`, `debug_flag`, `in_addr_mem_inst`, `in_ins_to_mem` and `wea_ram_inst` inputs.

## Interface
- `ADDR_W`, 8: instruction memory word-address width; depth is 2^ADDR_W words.
- `HALT_WORD`, 32'hFFFFFFFF: encoding of the halt instruction; marks end of program.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte, valid while `rx_done`=1.
- `rx_done`  in  1  single-cycle byte-valid strobe.
- `halt_flag`  in  1  from core, level, asserted when HALT retires.
- `cpu_reset`  out  1  to core `reset`.
- `cpu_enable`  out  1  core clock-enable / advance gate.
- `debug_flag`  out  1  to core; 1 in step mode.
- `wea_ram_inst`  out  1  instruction memory write strobe.
- `in_addr_mem_inst`  out  32  word index, zero-extended from ADDR_W bits.
- `in_ins_to_mem`  out  32  assembled instruction word.
- `word_count`  out  ADDR_W+1  number of words written in the last load.
- `done`  out  1  core halted.
- `error`  out  1  protocol or overflow error.

## Operation
- Command bytes are accepted in IDLE, LOADED and DONE:
  - 0x01 → LOAD.
  - 0x02 → RUN (LOADED/DONE only).
  - 0x03 → STEP_WAIT (LOADED/DONE only).
  - Any other byte, or 0x02/0x03 in IDLE → ERROR.
- LOAD:
  - Entering LOAD clears the byte counter (0..3), the word index and `word_count`.
  - Bytes are shifted in MSB-first; the first byte lands in [31:24].
  - On the 4th byte the word is written to `in_addr_mem_inst` = current index, then the index increments.
  - If the written word == HALT_WORD → LOADED (or CHECK, see Configuration).
  - If a word is written at index 2^ADDR_W−1 and it is not HALT_WORD → ERROR (overflow).
- RUN: `cpu_enable`=1 continuously. Bytes are ignored. `halt_flag`=1 → DONE.
- STEP_WAIT:
  - Byte 0x04 → STEP_PULSE. STEP_PULSE lasts one cycle with `cpu_enable`=1, then returns to STEP_WAIT.
  - Byte 0x02 → RUN.
  - Other bytes are ignored.
  - `halt_flag`=1 → DONE, with priority over a byte received in the same cycle.
- ERROR: only byte 0x00 (→ IDLE) or `reset` leaves this state.
- Output levels by state:
  - `cpu_reset`=1 in IDLE, LOAD, CHECK, LOADED and ERROR; 0 in RUN, STEP_* and DONE.
  - `debug_flag`=1 in STEP_WAIT and STEP_PULSE.
  - `done`=1 in DONE only.
  - `error`=1 in ERROR only.
- `word_count` holds the count of the last load, including the halt word, until the next LOAD.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, all other outputs 0, counters 0.
- All outputs are registered.
- `wea_ram_inst` pulses high for exactly one cycle, the cycle after the 4th byte's `rx_done`. Address and data are stable in that same cycle.
- State changes take effect one cycle after the triggering `rx_done` or `halt_flag`.
- `cpu_reset` deasserts in the first cycle of RUN/STEP_WAIT.
- `halt_flag` sampled in DONE has no effect.
- `reset` asserted mid-LOAD discards the partial word; no write occurs on the reset cycle. Memory contents are untouched.
- Minimum byte spacing is 1 cycle; back-to-back `rx_done` must be handled without loss.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the HALT_WORD write the FSM enters CHECK and waits for one byte.
  - That byte must equal the XOR of all data bytes received in LOAD, halt word included.
  - Match → LOADED; mismatch → ERROR.
- Not defined: CHECK state and the XOR accumulator are absent; the HALT_WORD write goes directly to LOADED.

## Test plan
- Reset, then send 01, 20 01 00 05, FF FF FF FF → writes 0x20010005 @0 and 0xFFFFFFFF @1, one strobe each; `word_count`=2; LOADED; `cpu_reset`=1.
- From LOADED send 02; hold `halt_flag`=1 after 10 cycles → `cpu_enable`=1 throughout RUN; `done`=1 one cycle after `halt_flag`; `cpu_reset` stays 0.
- From LOADED send 03, then 04 three times → `debug_flag`=1; exactly three single-cycle `cpu_enable` pulses; `halt_flag` coinciding with a 04 byte → DONE, no pulse.
- With ADDR_W=2, send 01 and four non-halt words → 4 writes at indices 0..3, then `error`=1; byte 00 → IDLE.
- Send 01, 12 34, assert `reset`, deassert, then send 01 and a full program → no write from the partial word; the new program loads at index 0.
- With `LOADER_CHECKSUM_EN`: load 20 01 00 05 + FF FF FF FF, then checksum 0x24 → LOADED; repeat with checksum 0x25 → `error`=1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Front-end for the MIPS core. Assembles big-endian 32-bit words from a
//   UART byte stream, writes them into instruction memory, then releases
//   the core in continuous (RUN) or single-step (STEP) mode and reports
//   completion once the core raises halt_flag.
//
//   Optional feature: define LOADER_CHECKSUM_EN to require a trailing
//   XOR checksum byte after the halt word (CHECK state).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   rx_data, rx_done  received byte and its single-cycle valid strobe
//   halt_flag         core has retired HALT (level)
//   cpu_reset         core reset, high while loading / idle / in error
//   cpu_enable        core advance gate (RUN, or one cycle per step)
//   debug_flag        high in step mode
//   wea_ram_inst      one-cycle instruction memory write strobe
//   in_addr_mem_inst  word index, zero-extended
//   in_ins_to_mem     assembled instruction word
//   word_count        words written by the last load (halt word included)
//   done, error       halted / protocol or overflow error
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              halt_flag,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              debug_flag,
  output logic              wea_ram_inst,
  output logic [31:0]       in_addr_mem_inst,
  output logic [31:0]       in_ins_to_mem,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_LOADED,
    S_RUN,
    S_STEP_WAIT,
    S_STEP_PULSE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         shift_q;      // first three bytes of the word in flight
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic [ADDR_W:0]     wcount_q;
  logic                wea_q;
  logic                cpu_reset_q, cpu_enable_q, debug_q, done_q, error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q;
`endif

  logic [31:0] word_next;
  logic        last_byte;
  logic        load_start;

  assign word_next  = {shift_q, rx_data};
  assign last_byte  = (state_q == S_LOAD) && rx_done && (byte_cnt_q == 2'd3);
  assign load_start = (state_d == S_LOAD) && (state_q != S_LOAD);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_done) state_d = (rx_data == 8'h01) ? S_LOAD : S_ERROR;
      end
      S_LOADED, S_DONE: begin
        // halt_flag is deliberately not looked at in DONE
        if (rx_done) begin
          case (rx_data)
            8'h01:   state_d = S_LOAD;
            8'h02:   state_d = S_RUN;
            8'h03:   state_d = S_STEP_WAIT;
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          if (word_next == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_LOADED;
`endif
          end else if (idx_q == {ADDR_W{1'b1}}) begin
            state_d = S_ERROR;   // last slot used without a halt word
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_done) state_d = (rx_data == xor_q) ? S_LOADED : S_ERROR;
      end
`endif
      S_RUN: begin
        if (halt_flag) state_d = S_DONE;
      end
      S_STEP_WAIT: begin
        // halt wins over a byte arriving in the same cycle
        if (halt_flag) state_d = S_DONE;
        else if (rx_done && rx_data == 8'h04) state_d = S_STEP_PULSE;
        else if (rx_done && rx_data == 8'h02) state_d = S_RUN;
      end
      S_STEP_PULSE: begin
        state_d = halt_flag ? S_DONE : S_STEP_WAIT;
      end
      S_ERROR: begin
        if (rx_done && rx_data == 8'h00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs. Outputs are decoded from
  // state_d so they change in the same cycle the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      idx_q        <= '0;
      addr_q       <= '0;
      data_q       <= 32'd0;
      wcount_q     <= '0;
      wea_q        <= 1'b0;
      cpu_reset_q  <= 1'b1;
      cpu_enable_q <= 1'b0;
      debug_q      <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wea_q   <= 1'b0;

      if (load_start) begin
        byte_cnt_q <= 2'd0;
        shift_q    <= 24'd0;
        idx_q      <= '0;
        wcount_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q      <= 8'd0;
`endif
      end else if (state_q == S_LOAD && rx_done) begin
        shift_q    <= {shift_q[15:0], rx_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        xor_q      <= xor_q ^ rx_data;
`endif
        if (byte_cnt_q == 2'd3) begin
          wea_q    <= 1'b1;
          addr_q   <= idx_q;
          data_q   <= word_next;
          idx_q    <= idx_q + 1'b1;
          wcount_q <= {1'b0, idx_q} + 1'b1;
        end
      end

      cpu_reset_q  <= (state_d == S_IDLE) || (state_d == S_LOAD) ||
`ifdef LOADER_CHECKSUM_EN
                      (state_d == S_CHECK) ||
`endif
                      (state_d == S_LOADED) || (state_d == S_ERROR);
      cpu_enable_q <= (state_d == S_RUN) || (state_d == S_STEP_PULSE);
      debug_q      <= (state_d == S_STEP_WAIT) || (state_d == S_STEP_PULSE);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERROR);
    end
  end

  assign cpu_reset        = cpu_reset_q;
  assign cpu_enable       = cpu_enable_q;
  assign debug_flag       = debug_q;
  assign wea_ram_inst     = wea_q;
  assign in_addr_mem_inst = {{(32-ADDR_W){1'b0}}, addr_q};
  assign in_ins_to_mem    = data_q;
  assign word_count       = wcount_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ADDR_W=2 so the overflow path is
// reachable with a short program). Expected memory writes are queued as
// words are sent and compared by a monitor when the write strobe appears.
module tb_program_loader;

  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          halt_flag;
  logic          cpu_reset;
  logic          cpu_enable;
  logic          debug_flag;
  logic          wea_ram_inst;
  logic [31:0]   in_addr_mem_inst;
  logic [31:0]   in_ins_to_mem;
  logic [AW:0]   word_count;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  program_loader #(.ADDR_W(AW), .HALT_WORD(32'hFFFFFFFF)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_done          (rx_done),
    .halt_flag        (halt_flag),
    .cpu_reset        (cpu_reset),
    .cpu_enable       (cpu_enable),
    .debug_flag       (debug_flag),
    .wea_ram_inst     (wea_ram_inst),
    .in_addr_mem_inst (in_addr_mem_inst),
    .in_ins_to_mem    (in_ins_to_mem),
    .word_count       (word_count),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued write
  always @(negedge clk) begin
    if (wea_ram_inst === 1'b1) begin
      logic [63:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write obs=%h/%h exp=none", in_addr_mem_inst, in_ins_to_mem);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({in_addr_mem_inst, in_ins_to_mem} === e) else begin
          errors++;
          $error("FAIL write obs=%h/%h exp=%h/%h", in_addr_mem_inst, in_ins_to_mem, e[63:32], e[31:0]);
        end
      end
      $display("write addr=%0d data=%h", in_addr_mem_inst, in_ins_to_mem);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge (back-to-back capable)
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; halt_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_enable",    {31'd0, cpu_enable}, 32'd0);
    chk("rst_flags",     {28'd0, debug_flag, done, error, wea_ram_inst}, 32'd0);
    chk("rst_wcount",    {29'd0, word_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic load: two words
    send(8'h01);
    chk("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send_word(32'd0, 32'h20010005);
    send_word(32'd1, 32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
    send(8'h24);
`endif
    @(negedge clk);
    chk("loaded_wcount", {29'd0, word_count}, 32'd2);
    chk("loaded_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("loaded_error", {31'd0, error}, 32'd0);

    // RUN until halt
    send(8'h02);
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("run_enable", {31'd0, cpu_enable}, 32'd1);
      @(negedge clk);
    end
    halt_flag = 1'b1;
    @(negedge clk);
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_done_enable", {31'd0, cpu_enable}, 32'd0);
    chk("run_done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    @(negedge clk);
    chk("done_hold", {31'd0, done}, 32'd1);
    halt_flag = 1'b0;

    // Step mode from DONE
    send(8'h03);
    chk("step_debug", {31'd0, debug_flag}, 32'd1);
    chk("step_idle_enable", {31'd0, cpu_enable}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(8'h04);
      chk("step_pulse", {31'd0, cpu_enable}, 32'd1);
      @(negedge clk);
      chk("step_pulse_end", {31'd0, cpu_enable}, 32'd0);
      chk("step_pulse_debug", {31'd0, debug_flag}, 32'd1);
    end
    send(8'h55);  // ignored in STEP_WAIT
    chk("step_ignore", {30'd0, debug_flag, cpu_enable}, 32'd2);
    halt_flag = 1'b1;
    send(8'h04);
    halt_flag = 1'b0;
    chk("step_halt_done", {31'd0, done}, 32'd1);
    chk("step_halt_nopulse", {31'd0, cpu_enable}, 32'd0);
    chk("step_halt_debug", {31'd0, debug_flag}, 32'd0);

    // Overflow: four non-halt words fill the 4-deep memory
    send(8'h01);
    send_word(32'd0, 32'h11223344);
    send_word(32'd1, 32'h55667788);
    send_word(32'd2, 32'h99AABBCC);
    chk("ovf_no_err_yet", {31'd0, error}, 32'd0);
    send_word(32'd3, 32'h0D0E0F10);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_wcount", {29'd0, word_count}, 32'd4);
    send(8'h01);  // only 00 leaves ERROR
    chk("err_sticky", {31'd0, error}, 32'd1);
    send(8'h00);
    chk("err_exit", {31'd0, error}, 32'd0);
    chk("err_idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // RUN from IDLE is a protocol error
    send(8'h02);
    chk("idle_run_error", {31'd0, error}, 32'd1);
    send(8'h00);

    // Reset in the middle of a word
    send(8'h01);
    send(8'h12);
    send(8'h34);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_wcount", {29'd0, word_count}, 32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send(8'h01);
    send_word(32'd0, 32'hAABBCCDD);
    send_word(32'd1, 32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    @(negedge clk);
    chk("reload_wcount", {29'd0, word_count}, 32'd2);
    chk("reload_error", {31'd0, error}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum
    send(8'h01);
    send_word(32'd0, 32'h20010005);
    send_word(32'd1, 32'hFFFFFFFF);
    chk("cks_wait_error", {31'd0, error}, 32'd0);
    send(8'h25);
    chk("cks_bad_error", {31'd0, error}, 32'd1);
    send(8'h00);
`endif

    repeat (3) @(negedge clk);
    chk("writes_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
